prog_delay_line: RTL and testbench
==================================

PROG_DELAY_LINE -- requirements
Module: prog_delay_line

Interface
REQ-001 Parameter WIDTH, default 8: data bits per sample.
REQ-002 Parameter MAX_DEPTH, default 16: largest delay in enabled cycles, minimum 2.
REQ-003 Derived constant DLY_W = $clog2(MAX_DEPTH+1): width of the delay-select port.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  advance enable; when low, the line is stalled.
REQ-007 flush  input  1  synchronous clear of all in-flight samples.
REQ-008 dly  input  DLY_W  requested delay D in enabled cycles.
REQ-009 din  input  WIDTH  input sample.
REQ-010 din_vld  input  1  qualifier for din.
REQ-011 dout  output  WIDTH  delayed sample, registered.
REQ-012 dout_vld  output  1  delayed qualifier, registered.
REQ-013 dly_act  output  DLY_W  effective (clamped) delay currently in use, registered.

Function
REQ-014 Clamp the effective delay: dly=0 uses 1; dly>MAX_DEPTH uses MAX_DEPTH; otherwise dly is used unchanged.
REQ-015 With en=1 on every edge and D constant, a sample taken at edge n shall appear on dout/dout_vld immediately after edge n+D-1, giving latency D clock cycles (D=1 is one register stage).
REQ-016 The line advances only on edges with en=1; when en=0, dout, dout_vld, the storage and the write pointer shall all hold, and din is ignored.
REQ-017 Latency counts enabled edges only, so a sample sits behind exactly D-1 further enabled edges regardless of stall gaps.
REQ-018 Storage is a MAX_DEPTH-entry circular buffer with a write pointer that wraps from MAX_DEPTH-1 to 0; each entry holds data plus a valid bit.
REQ-019 dout_vld=1 only for samples written with din_vld=1 since the last reset, flush or delay change.
REQ-020 dout carries the stored data even when dout_vld=0; consumers shall ignore it.
REQ-021 flush=1 on an edge clears every valid bit and sets dout_vld=0; din on that edge is discarded; flush takes effect regardless of en.
REQ-022 If the clamped dly differs from dly_act at an edge, treat that edge as a flush, load dly_act with the new value, and time subsequent latency from the new value.
REQ-023 If flush and a delay change coincide, take one flush action and still load the new dly_act.
REQ-024 After a flush, reset or delay change, dout_vld stays 0 until the first valid sample written afterwards has traversed D enabled edges.
REQ-025 Changing dly within the same clamp class (for example 0 to 1) is not a change, and the line does not flush.

Reset
REQ-026 While rst=1 at an edge: dout=0, dout_vld=0, all valid bits=0, write pointer=0, and dly_act=clamp(dly).
REQ-027 rst has priority over flush, en and a delay change; reset mid-stream discards all in-flight samples.
REQ-028 Data contents of the storage array need not be reset.

Structure
REQ-029 The shared package delay_pkg holds the default WIDTH/MAX_DEPTH constants and the clamp function used for dly and dly_act.
REQ-030 The storage array is one sub-module, delay_ram: MAX_DEPTH x (WIDTH+1), one write port, one asynchronous read port, and a synchronous valid-clear input.
REQ-031 Pointer arithmetic, read index = (wp - (D-1)) mod MAX_DEPTH, resides in prog_delay_line.
REQ-032 The RTL shall have no latches, no combinational path from din to dout, and shall synthesise for any MAX_DEPTH in the range 2..256.

Verification
REQ-033 Steady stream: WIDTH=8, MAX_DEPTH=16, dly=4, en=1, din=0x01,0x02,... with din_vld=1 -> dout=0x01 with dout_vld=1 exactly 4 cycles after 0x01 is applied, then one value per cycle with no gaps.
REQ-034 Stall: dly=3, en toggles 1,0,1,0,... -> each sample emerges after 3 enabled edges, and dout holds unchanged on every en=0 cycle.
REQ-035 Clamp: dly=0 -> dly_act=1 and latency 1; dly=31 -> dly_act=16, latency 16, and the write pointer wraps without data corruption over 40 samples.
REQ-036 Delay change: streaming at dly=4, switch to dly=2 -> dout_vld falls on the change edge and reasserts 2 cycles after the first new valid sample, with no stale samples emitted.
REQ-037 Flush and reset: flush asserted with 5 valid samples in flight -> none of them ever appears with dout_vld=1; rst mid-stream -> dout=0 and dout_vld=0 on the next cycle.
REQ-038 Bubbles: din_vld pattern 1,0,1,1,0 at dly=5 -> dout_vld reproduces 1,0,1,1,0 exactly 5 cycles later.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared constants and delay clamp helper for the programmable delay line.
package delay_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_DEPTH = 16;

  // Maps a requested delay onto the legal range 1..max_d.
  function automatic int unsigned clamp_dly(input int unsigned d, input int unsigned max_d);
    if (d == 0)     return 1;
    if (d > max_d)  return max_d;
    return d;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Circular sample store: data entries plus valid bits, async read, sync valid clear.
module delay_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wvld,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvld
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  // Clear wins over a same-edge write so a flushed sample can never survive.
  always_comb begin
    vld_d = vld_q;
    if (clr) begin
      vld_d = '0;
    end else if (we) begin
      vld_d[waddr] = wvld;
    end
  end

  always_ff @(posedge clk) begin
    vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
  assign rvld  = vld_q[raddr];

endmodule

// File: rtl/prog_delay_line.sv
// Programmable delay line: latency of dly enabled cycles (clamped to 1..MAX_DEPTH).
// A change of the clamped delay or a flush discards every in-flight sample.
module prog_delay_line
  import delay_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int MAX_DEPTH = DEF_MAX_DEPTH,
  localparam int DLY_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [DLY_W-1:0] dly,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [DLY_W-1:0] dly_act
);

  localparam int          AW      = $clog2(MAX_DEPTH);
  localparam int unsigned DEPTH_U = MAX_DEPTH;

  logic [AW-1:0]    wp_q, wp_d, wp_inc, rd_idx;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic [DLY_W-1:0] dly_act_q, dly_act_d, dly_clamp;
  logic             dly_chg;
  logic             ram_we, ram_clr;
  logic [WIDTH-1:0] ram_rdata;
  logic             ram_rvld;
  int unsigned      rd_off, rd_sum;

  always_comb begin
    dly_clamp = DLY_W'(clamp_dly(32'(dly), DEPTH_U));
    dly_chg   = (dly_clamp != dly_act_q);
    wp_inc    = (wp_q == AW'(MAX_DEPTH - 1)) ? '0 : wp_q + AW'(1);
    // Read index is wp - (D-1) modulo MAX_DEPTH, done without a divider.
    rd_off    = 32'(dly_act_q) - 32'd1;
    rd_sum    = 32'(wp_q) + DEPTH_U - rd_off;
    if (rd_sum >= DEPTH_U) begin
      rd_sum = rd_sum - DEPTH_U;
    end
    rd_idx    = AW'(rd_sum);
  end

  always_comb begin
    wp_d       = wp_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    dly_act_d  = dly_act_q;
    ram_we     = 1'b0;
    ram_clr    = 1'b0;
    if (flush || dly_chg) begin
      ram_clr    = 1'b1;
      dout_vld_d = 1'b0;
      dly_act_d  = dly_clamp;
    end else if (en) begin
      ram_we = 1'b1;
      wp_d   = wp_inc;
      // D=1 is a single register stage: the entry being written is the one to emit.
      if (dly_act_q == DLY_W'(1)) begin
        dout_d     = din;
        dout_vld_d = din_vld;
      end else begin
        dout_d     = ram_rdata;
        dout_vld_d = ram_rvld;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dly_act_q  <= dly_clamp;
    end else begin
      wp_q       <= wp_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dly_act_q  <= dly_act_d;
    end
  end

  delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH)
  ) u_ram (
    .clk   (clk),
    .clr   (ram_clr | rst),
    .we    (ram_we & ~rst),
    .waddr (wp_q),
    .wdata (din),
    .wvld  (din_vld),
    .raddr (rd_idx),
    .rdata (ram_rdata),
    .rvld  (ram_rvld)
  );

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dly_act  = dly_act_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed self-checking bench for prog_delay_line (WIDTH=8, MAX_DEPTH=16).
module tb_prog_delay_line;

  logic       clk = 1'b0;
  logic       rst, en, flush, din_vld;
  logic [4:0] dly;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_vld;
  logic [4:0] dly_act;
  logic [4:0] pat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_delay_line #(.WIDTH(8), .MAX_DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .dly      (dly),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dly_act  (dly_act)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [7:0] d, input logic v);
    en      = e;
    din     = d;
    din_vld = v;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; dly = 5'd4; din = 8'h00; din_vld = 1'b0;
    pat = 5'b01101;  // din_vld 1,0,1,1,0 from bit 0 upward

    step();
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_act", dly_act, 4);
    rst = 1'b0;

    // steady stream at D=4
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'(i + 1), 1'b1);
      step();
      chk("steady_vld", dout_vld, 32'(i >= 3));
      if (i >= 3) chk("steady_dout", dout, 32'(i - 2));
    end

    // delay change 4 -> 2
    dly = 5'd2;
    drive(1'b1, 8'h0D, 1'b1);
    step();
    chk("chg_vld", dout_vld, 0);
    chk("chg_act", dly_act, 2);
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 8'(8'h20 + j), 1'b1);
      step();
      chk("chg2_vld", dout_vld, 32'(j >= 1));
      if (j >= 1) chk("chg2_dout", dout, 32'(8'h20 + j - 1));
    end

    // stall pattern at D=3
    dly = 5'd3;
    drive(1'b1, 8'h00, 1'b0);
    step();
    chk("stall_chg_vld", dout_vld, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'(8'h40 + k), 1'b1);
      step();
      chk("stall_en_vld", dout_vld, 32'(k >= 2));
      if (k >= 2) chk("stall_en_dout", dout, 32'(8'h40 + k - 2));
      drive(1'b0, 8'hEE, 1'b1);
      step();
      chk("stall_hold_vld", dout_vld, 32'(k >= 2));
      if (k >= 2) chk("stall_hold_dout", dout, 32'(8'h40 + k - 2));
    end

    // clamp dly=0 -> 1, then dly=1 is the same class
    dly = 5'd0;
    drive(1'b1, 8'h00, 1'b0);
    step();
    chk("clamp0_vld", dout_vld, 0);
    chk("clamp0_act", dly_act, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h60 + k), 1'b1);
      step();
      chk("clamp0_vld1", dout_vld, 1);
      chk("clamp0_dout", dout, 32'(8'h60 + k));
    end
    dly = 5'd1;
    drive(1'b1, 8'h70, 1'b1);
    step();
    chk("same_class_act", dly_act, 1);
    chk("same_class_vld", dout_vld, 1);
    chk("same_class_dout", dout, 32'h70);

    // bubbles at D=5
    dly = 5'd5;
    drive(1'b1, 8'h00, 1'b0);
    step();
    chk("bub_act", dly_act, 5);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h81 + i), (i < 5) ? pat[i] : 1'b0);
      step();
      if (i >= 4) begin
        chk("bub_vld", dout_vld, 32'((i - 4 < 5) ? pat[i - 4] : 1'b0));
        chk("bub_dout", dout, 32'(8'h81 + i - 4));
      end else begin
        chk("bub_pre_vld", dout_vld, 0);
      end
    end

    // clamp dly=31 -> 16, pointer wraps over 40 samples
    dly = 5'd31;
    drive(1'b1, 8'h00, 1'b0);
    step();
    chk("clamp31_act", dly_act, 16);
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 8'(8'hA0 + k), 1'b1);
      step();
      chk("clamp31_vld", dout_vld, 32'(k >= 15));
      if (k >= 15) chk("clamp31_dout", dout, 32'(8'hA0 + k - 15));
    end

    // flush with 5 valid samples in flight at D=8
    dly = 5'd8;
    drive(1'b1, 8'h00, 1'b0);
    step();
    chk("flush_act", dly_act, 8);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'hD0 + k), 1'b1);
      step();
      chk("flush_fill_vld", dout_vld, 0);
    end
    flush = 1'b1;
    drive(1'b1, 8'hFF, 1'b1);
    step();
    chk("flush_edge_vld", dout_vld, 0);
    flush = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'h00, 1'b0);
      step();
      chk("flush_after_vld", dout_vld, 0);
    end
    drive(1'b1, 8'hE0, 1'b1);
    step();
    chk("post_flush_vld", dout_vld, 0);
    for (int k = 1; k < 8; k++) begin
      drive(1'b1, 8'h00, 1'b0);
      step();
      chk("post_flush_vld", dout_vld, 32'(k == 7));
      if (k == 7) chk("post_flush_dout", dout, 32'hE0);
    end

    // reset mid-stream
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(8'hF0 + k), 1'b1);
      step();
      chk("pre_rst_vld", dout_vld, 32'(k >= 7));
      if (k >= 7) chk("pre_rst_dout", dout, 32'(8'hF0 + k - 7));
    end
    rst = 1'b1;
    drive(1'b1, 8'h55, 1'b1);
    step();
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_vld", dout_vld, 0);
    chk("mid_rst_act", dly_act, 8);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h30 + k), 1'b1);
      step();
      chk("post_rst_vld", dout_vld, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
